// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN to receive 8E1 frames (even parity bit before stop).
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // Handshake: rx_valid is a single-cycle strobe with no ready; rx_data is
  // updated on exactly the cycle rx_valid is high and held until the next one.
  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          stop_ok;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign stop_ok = rx_s && !par_bad;
`else
  assign stop_ok = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      rx_m     <= rx;
      rx_s     <= rx_m;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
          par_bad <= 1'b0;
`endif
          if (!rx_s) state <= START;
        end
        START: begin
          // A start bit that is high again at mid-bit was a glitch.
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            par_bad <= (rx_s != ^shift);
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          // Leave at mid-stop so an immediately following start bit is seen.
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (stop_ok) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
